// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the MEM->WB vector pipeline register.
package pipe_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  // LSB position of lane i in a packed multi-lane bus
  function automatic int lane(input int i, input int width);
    return i * width;
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register with valid; state changes on the falling clock edge.
module pipe_slot #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          i_sclr,
  input  logic          i_load,
  input  logic          i_valid,
  input  logic [PW-1:0] i_data,
  output logic          o_valid,
  output logic [PW-1:0] o_data
);

  logic          r_valid;
  logic [PW-1:0] r_data;

  // Sync clear drops only the valid; stale payload is harmless once invalid
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_sclr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= i_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_mw_vec.sv
// MEM->WB pipeline register: LANES data lanes, valid/ready with one-entry skid, flush, stall counter.
module pipe_mw_vec
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int LANES      = 4,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic                    FLUSH,
  input  logic                    VALID_M,
  output logic                    READY_M,
  input  logic                    REG_WRITE_M,
  input  logic                    MEM_TO_REG_M,
  input  logic [LANES-1:0]        LANE_MASK_M,
  input  logic [LANES*WIDTH-1:0]  READ_DATA_M,
  input  logic [LANES*WIDTH-1:0]  ALU_OUT_M,
  input  logic [REG_ADDR_W-1:0]   WRITE_REG_M,
  output logic                    VALID_W,
  input  logic                    READY_W,
  output logic                    REG_WRITE_W,
  output logic [LANES-1:0]        LANE_MASK_W,
  output logic [LANES*WIDTH-1:0]  RESULT_W,
  output logic [REG_ADDR_W-1:0]   WRITE_REG_W,
  output logic [CNT_W-1:0]        STALL_CNT
);

  localparam int DW      = LANES * WIDTH;
  localparam int PW      = 2 + LANES + 2 * DW + REG_ADDR_W;
  localparam int ALU_LSB = REG_ADDR_W;
  localparam int RD_LSB  = REG_ADDR_W + DW;
  localparam int MSK_LSB = REG_ADDR_W + 2 * DW;
  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  logic          w_acc, w_free;
  logic          w_out_v, w_skid_v;
  logic [PW-1:0] w_in_pl, w_out_pl, w_skid_pl, w_out_next;
  logic [CNT_W-1:0] r_cnt;

  assign w_in_pl = {REG_WRITE_M, MEM_TO_REG_M, LANE_MASK_M, READ_DATA_M, ALU_OUT_M, WRITE_REG_M};
  assign READY_M = ~w_skid_v;
  assign w_acc   = VALID_M & READY_M;
  assign w_free  = ~w_out_v | READY_W;

  // Skid contents take precedence so ordering stays FIFO
  assign w_out_next = w_skid_v ? w_skid_pl : w_in_pl;

  pipe_slot #(.PW(PW)) u_out_slot (
    .clk     (CLK),
    .clr     (CLR),
    .i_sclr  (FLUSH),
    .i_load  (w_free),
    .i_valid (w_skid_v | w_acc),
    .i_data  (w_out_next),
    .o_valid (w_out_v),
    .o_data  (w_out_pl)
  );

  pipe_slot #(.PW(PW)) u_skid_slot (
    .clk     (CLK),
    .clr     (CLR),
    .i_sclr  (FLUSH | (w_free & w_skid_v)),
    .i_load  (~w_free & w_acc),
    .i_valid (1'b1),
    .i_data  (w_in_pl),
    .o_valid (w_skid_v),
    .o_data  (w_skid_pl)
  );

  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      r_cnt <= '0;
    end else if (w_out_v & ~READY_W & ~FLUSH) begin
      r_cnt <= CNT_W'(sat_inc(64'(r_cnt), CNT_MAX));
    end
  end

  assign STALL_CNT   = r_cnt;
  assign VALID_W     = w_out_v;
  assign REG_WRITE_W = w_out_v & w_out_pl[PW-1];
  assign LANE_MASK_W = w_out_pl[MSK_LSB +: LANES] & {LANES{REG_WRITE_W}};
  assign WRITE_REG_W = w_out_pl[REG_ADDR_W-1:0];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam int LSB = lane(gi, WIDTH);
      assign RESULT_W[LSB +: WIDTH] = w_out_pl[PW-2] ? w_out_pl[RD_LSB + LSB +: WIDTH]
                                                     : w_out_pl[ALU_LSB + LSB +: WIDTH];
    end
  endgenerate

endmodule
